// File: rtl/npc_mem_pkg.sv
// Shared types and constants for the NPC memory arbiter slice.
package npc_mem_pkg;

    localparam int XLEN   = 64;
    localparam int MASK_W = 8;

    localparam logic [XLEN-1:0] PMEM_BASE = 64'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } arb_state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the arbiter and physical memory.
interface mem_arbiter_if;
    import npc_mem_pkg::*;

    logic              if_req_valid;
    logic              if_req_ready;
    logic [XLEN-1:0]   if_addr;
    logic              if_resp_valid;
    logic [XLEN-1:0]   if_rdata;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [XLEN-1:0]   ls_addr;
    logic              ls_wen;
    logic [XLEN-1:0]   ls_wdata;
    logic [MASK_W-1:0] ls_wmask;
    logic              ls_resp_valid;
    logic [XLEN-1:0]   ls_rdata;

    logic [XLEN-1:0]   mem_raddr;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_wmask;

    // Arbiter side.
    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

    // Requester / memory side.
    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_rr_pick.sv
// Two-way round-robin pick: a lone valid always wins, a tie goes to the one not served last.
module mem_rr_pick
    import npc_mem_pkg::*;
(
    input  logic    if_valid_i,
    input  logic    ls_valid_i,
    input  req_id_e last_i,
    output logic    grant_if_o,
    output logic    grant_ls_o
);

    // Grant decode from the valids and the last-served pointer.
    always_comb begin
        grant_if_o = 1'b0;
        grant_ls_o = 1'b0;
        if (if_valid_i && ls_valid_i) begin
            grant_if_o = (last_i == REQ_LSU);
            grant_ls_o = (last_i == REQ_IFU);
        end else begin
            grant_if_o = if_valid_i;
            grant_ls_o = ls_valid_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one fixed-latency physical memory port.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int unsigned      LATENCY        = 2,
    parameter logic [XLEN-1:0]  PMEM_IDLE_ADDR = PMEM_BASE
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave arb_if
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    arb_state_e        state_q;
    req_id_e           last_q;
    req_id_e           id_q;
    logic [3:0]        cnt_q;
    logic [XLEN-1:0]   addr_q;
    logic              wen_q;
    logic [XLEN-1:0]   wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [XLEN-1:0]   if_rdata_q;
    logic [XLEN-1:0]   ls_rdata_q;
    logic              if_resp_q;
    logic              ls_resp_q;

    logic grant_if;
    logic grant_ls;
    logic if_ready;
    logic ls_ready;
    logic final_busy;

    mem_rr_pick u_pick (
        .if_valid_i (arb_if.if_req_valid),
        .ls_valid_i (arb_if.ls_req_valid),
        .last_i     (last_q),
        .grant_if_o (grant_if),
        .grant_ls_o (grant_ls)
    );

    // Ready is suppressed while reset is held so nothing can be accepted against a stale state.
    assign if_ready   = !rst && (state_q == ST_IDLE) && grant_if;
    assign ls_ready   = !rst && (state_q == ST_IDLE) && grant_ls;
    assign final_busy = !rst && (state_q == ST_BUSY) && (cnt_q == 4'd0);

    assign arb_if.if_req_ready  = if_ready;
    assign arb_if.ls_req_ready  = ls_ready;
    assign arb_if.if_resp_valid = if_resp_q;
    assign arb_if.ls_resp_valid = ls_resp_q;
    assign arb_if.if_rdata      = if_rdata_q;
    assign arb_if.ls_rdata      = ls_rdata_q;

    // Transaction FSM: accept, count down the memory latency, then one response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= REQ_LSU;
            id_q       <= REQ_IFU;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_resp_q  <= 1'b0;
            ls_resp_q  <= 1'b0;
        end else begin
            if_resp_q <= 1'b0;
            ls_resp_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ls_ready) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CNT_INIT;
                        id_q    <= REQ_LSU;
                        last_q  <= REQ_LSU;
                        addr_q  <= arb_if.ls_addr;
                        wen_q   <= arb_if.ls_wen;
                        wdata_q <= arb_if.ls_wdata;
                        wmask_q <= arb_if.ls_wmask;
                    end else if (if_ready) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CNT_INIT;
                        id_q    <= REQ_IFU;
                        last_q  <= REQ_IFU;
                        addr_q  <= arb_if.if_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                        if (id_q == REQ_LSU) begin
                            ls_rdata_q <= wen_q ? '0 : arb_if.mem_rdata;
                            ls_resp_q  <= 1'b1;
                        end else begin
                            if_rdata_q <= arb_if.mem_rdata;
                            if_resp_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory port: read address held through BUSY, write strobes only on the last BUSY cycle.
    always_comb begin
        arb_if.mem_raddr = PMEM_IDLE_ADDR;
        arb_if.mem_waddr = PMEM_IDLE_ADDR;
        arb_if.mem_wdata = '0;
        arb_if.mem_wmask = '0;
        if (!rst && state_q == ST_BUSY) begin
            arb_if.mem_raddr = addr_q;
            if (final_busy && wen_q) begin
                arb_if.mem_waddr = addr_q;
                arb_if.mem_wdata = wdata_q;
                arb_if.mem_wmask = wmask_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level memory/arbitration model.
module tb_mem_arbiter;
    import npc_mem_pkg::*;

    localparam int          L2     = 2;
    localparam int          L1     = 1;
    localparam logic [63:0] RD_XOR = 64'h5A5A_0F0F_C3C3_9696;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if b2 ();
    mem_arbiter_if b1 ();

    mem_arbiter #(.LATENCY(L2), .PMEM_IDLE_ADDR(PMEM_BASE)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .arb_if (b2)
    );

    mem_arbiter #(.LATENCY(L1), .PMEM_IDLE_ADDR(PMEM_BASE)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .arb_if (b1)
    );

    // Physical memory seen by dut2, and the model's view of what it should contain.
    logic [63:0] mem2    [32];
    logic [63:0] ref_mem [32];
    logic        last_ls;
    logic [63:0] ref_if_rd;
    logic [63:0] ref_ls_rd;
    int n_chk = 0;
    int n_err = 0;

    function automatic logic in_rng(input logic [63:0] a);
        return a[63:8] == PMEM_BASE[63:8];
    endfunction

    assign b2.mem_rdata = in_rng(b2.mem_raddr) ? mem2[b2.mem_raddr[7:3]] : 64'h0;
    assign b1.mem_rdata = b1.mem_raddr ^ RD_XOR;

    always @(posedge clk) begin
        if (b2.mem_wmask != 8'h00 && in_rng(b2.mem_waddr)) begin
            for (int b = 0; b < 8; b++)
                if (b2.mem_wmask[b]) mem2[b2.mem_waddr[7:3]][8*b +: 8] = b2.mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd_addr();
        logic [4:0] i;
        i = 5'($urandom_range(0, 31));
        return PMEM_BASE + {56'd0, i, 3'b000};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        b2.if_req_valid = 1'b1; b2.ls_req_valid = 1'b1;
        b2.if_addr = PMEM_BASE; b2.ls_addr = PMEM_BASE;
        b2.ls_wen = 1'b1; b2.ls_wmask = 8'hFF; b2.ls_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        b1.ls_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_if_ready",  64'(b2.if_req_ready), 64'd0);
        chk("rst_ls_ready",  64'(b2.ls_req_ready), 64'd0);
        chk("rst1_ls_ready", 64'(b1.ls_req_ready), 64'd0);
        chk("rst_if_resp",   64'(b2.if_resp_valid), 64'd0);
        chk("rst_ls_resp",   64'(b2.ls_resp_valid), 64'd0);
        chk("rst_wmask",     64'(b2.mem_wmask), 64'd0);
        chk("rst_raddr",     b2.mem_raddr, PMEM_BASE);
        chk("rst_waddr",     b2.mem_waddr, PMEM_BASE);
        chk("rst_wdata",     b2.mem_wdata, 64'd0);
        chk("rst_if_rdata",  b2.if_rdata, 64'd0);
        chk("rst_ls_rdata",  b2.ls_rdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        b2.if_req_valid = 1'b0; b2.ls_req_valid = 1'b0; b1.ls_req_valid = 1'b0;
        last_ls   = 1'b1;
        ref_if_rd = 64'd0;
        ref_ls_rd = 64'd0;
    endtask

    // One full transaction on dut2; called just after a rising edge with dut2 idle.
    task automatic run_txn(input logic iv, input logic [63:0] ia, input logic lv,
                           input logic [63:0] la, input logic w, input logic [63:0] wd,
                           input logic [7:0] wm);
        logic        pick_ls;
        logic [63:0] a;
        logic        is_wr;
        logic [63:0] exp_rd;
        int          pulses;
        pick_ls = (iv && lv) ? !last_ls : lv;
        a       = pick_ls ? la : ia;
        is_wr   = pick_ls && w;
        b2.if_req_valid = iv; b2.if_addr = ia;
        b2.ls_req_valid = lv; b2.ls_addr = la;
        b2.ls_wen = w; b2.ls_wdata = wd; b2.ls_wmask = wm;
        @(negedge clk);
        chk("if_req_ready", 64'(b2.if_req_ready), 64'(iv && !pick_ls));
        chk("ls_req_ready", 64'(b2.ls_req_ready), 64'(lv && pick_ls));
        @(posedge clk); #1;
        last_ls = pick_ls;
        b2.if_req_valid = 1'($urandom); b2.ls_req_valid = 1'($urandom);
        b2.if_addr = rnd_addr(); b2.ls_addr = rnd_addr();
        b2.ls_wen = 1'($urandom); b2.ls_wdata = {$urandom, $urandom}; b2.ls_wmask = 8'($urandom);
        exp_rd = is_wr ? 64'd0 : ref_mem[a[7:3]];
        pulses = 0;
        for (int k = 1; k <= L2 + 1; k++) begin
            @(negedge clk);
            if (b2.mem_wmask != 8'h00) pulses++;
            chk("ready_in_access", 64'({b2.if_req_ready, b2.ls_req_ready}), 64'd0);
            if (k <= L2) chk("raddr_busy", b2.mem_raddr, a);
            else         chk("raddr_resp", b2.mem_raddr, PMEM_BASE);
            chk("if_resp_valid", 64'(b2.if_resp_valid), 64'(k == L2 + 1 && !pick_ls));
            chk("ls_resp_valid", 64'(b2.ls_resp_valid), 64'(k == L2 + 1 && pick_ls));
        end
        if (pick_ls) ref_ls_rd = exp_rd;
        else         ref_if_rd = exp_rd;
        chk("if_rdata", b2.if_rdata, ref_if_rd);
        chk("ls_rdata", b2.ls_rdata, ref_ls_rd);
        chk("wmask_pulses", 64'(pulses), 64'((is_wr && wm != 8'h00) ? 1 : 0));
        if (is_wr) ref_mem[a[7:3]] = merge(ref_mem[a[7:3]], wd, wm);
        @(posedge clk); #1;
        b2.if_req_valid = 1'b0; b2.ls_req_valid = 1'b0;
        chk("mem_content", mem2[a[7:3]], ref_mem[a[7:3]]);
    endtask

    initial begin
        logic [63:0] cur;
        logic [63:0] acc;
        logic        iv;
        logic        lv;
        int          bad;
        b2.if_req_valid = 1'b0; b2.if_addr = '0; b2.ls_req_valid = 1'b0; b2.ls_addr = '0;
        b2.ls_wen = 1'b0; b2.ls_wdata = '0; b2.ls_wmask = '0;
        b1.if_req_valid = 1'b0; b1.if_addr = '0; b1.ls_req_valid = 1'b0; b1.ls_addr = '0;
        b1.ls_wen = 1'b0; b1.ls_wdata = '0; b1.ls_wmask = '0;
        for (int i = 0; i < 32; i++) begin
            mem2[i]    = {$urandom, $urandom};
            ref_mem[i] = mem2[i];
        end
        #1;
        do_reset();

        // Three ties after reset: IFU, LSU, IFU.
        for (int t = 0; t < 3; t++)
            run_txn(1'b1, rnd_addr(), 1'b1, rnd_addr(), 1'b0, 64'd0, 8'h00);

        do_reset();
        // Lone fetch of the base word.
        run_txn(1'b1, PMEM_BASE, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
        // Partial-mask store, then read it back.
        run_txn(1'b0, 64'd0, 1'b1, PMEM_BASE + 64'h10, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
        run_txn(1'b0, 64'd0, 1'b1, PMEM_BASE + 64'h10, 1'b0, 64'd0, 8'h00);
        // Zero-mask store still responds, memory untouched.
        run_txn(1'b0, 64'd0, 1'b1, PMEM_BASE + 64'h20, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);

        // Reset during the first BUSY cycle of a store.
        b2.ls_req_valid = 1'b1; b2.ls_addr = PMEM_BASE + 64'h18;
        b2.ls_wen = 1'b1; b2.ls_wdata = 64'hFFFF_FFFF_FFFF_FFFF; b2.ls_wmask = 8'hFF;
        @(negedge clk);
        chk("mid_ls_ready", 64'(b2.ls_req_ready), 64'd1);
        @(posedge clk); #1;
        b2.ls_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (b2.mem_wmask != 8'h00 || b2.ls_resp_valid || b2.if_resp_valid) bad++;
        end
        chk("mid_rst_no_pulse_no_resp", 64'(bad), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_ls = 1'b1; ref_if_rd = 64'd0; ref_ls_rd = 64'd0;
        chk("mid_rst_mem", mem2[3], ref_mem[3]);
        run_txn(1'b0, 64'd0, 1'b1, PMEM_BASE + 64'h18, 1'b0, 64'd0, 8'h00);

        // LATENCY=1 instance, LSU held valid: accept every third cycle.
        cur = rnd_addr();
        acc = 64'd0;
        b1.ls_req_valid = 1'b1; b1.ls_addr = cur;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("l1_ls_ready", 64'(b1.ls_req_ready), 64'(c % 3 == 0));
            chk("l1_ls_resp",  64'(b1.ls_resp_valid), 64'(c % 3 == 2));
            chk("l1_wmask",    64'(b1.mem_wmask), 64'd0);
            if (c % 3 == 2) chk("l1_ls_rdata", b1.ls_rdata, acc ^ RD_XOR);
            if (c % 3 == 0) acc = cur;
            @(posedge clk); #1;
            cur = rnd_addr();
            b1.ls_addr = cur;
        end
        b1.ls_req_valid = 1'b0;

        // Random mix of fetches, loads and stores with occasional idle cycles.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_ready", 64'({b2.if_req_ready, b2.ls_req_ready}), 64'd0);
                @(posedge clk); #1;
            end
            iv = 1'($urandom);
            lv = 1'($urandom);
            if (!iv && !lv) lv = 1'b1;
            run_txn(iv, rnd_addr(), lv, rnd_addr(), 1'($urandom), {$urandom, $urandom},
                    ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
